// File: rtl/sm_dbg_pkg.sv
// Shared definitions for the debug register dumper: state encoding,
// frame constants and timer sizing.
package sm_dbg_pkg;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE    = 3'd0;
  localparam state_t ST_HEADER  = 3'd1;
  localparam state_t ST_SETTLE  = 3'd2;
  localparam state_t ST_CAPTURE = 3'd3;
  localparam state_t ST_SEND    = 3'd4;
  localparam state_t ST_DONE    = 3'd5;

  localparam logic [7:0] HEADER_DEFAULT = 8'hA5;
  localparam logic [4:0] REG_LAST       = 5'd31;
  localparam int         BYTES_PER_REG  = 4;
  localparam int         CNT_W          = 8;

  // Value loaded into the settle timer so the SETTLE state lasts exactly `settle` cycles.
  function automatic logic [CNT_W-1:0] settle_load(input int settle);
    return CNT_W'(settle - 1);
  endfunction

endpackage

// File: rtl/sm_dbg_settle_timer.sv
// Loadable down-counter with a registered-state expired flag; stops at zero
// so it never wraps.
module sm_dbg_settle_timer
  import sm_dbg_pkg::*;
#(
  parameter int W = CNT_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         expired
);

  logic [W-1:0] cnt_d, cnt_q;

  // Load has priority over decrement; saturate at zero.
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (dec && (cnt_q != '0)) begin
      cnt_d = cnt_q - W'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired = (cnt_q == '0);

endmodule

// File: rtl/sm_reg_dumper.sv
// Walks the CPU debug register port x0..x31 and streams a framed byte dump
// (sync byte + 128 little-endian data bytes) over a valid/ready interface.
module sm_reg_dumper
  import sm_dbg_pkg::*;
#(
  parameter int         SETTLE = 4,
  parameter logic [7:0] HEADER = HEADER_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  output logic [4:0]  regAddr,
  input  logic [31:0] regData,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        busy,
  output logic        done
);

  localparam logic [CNT_W-1:0] SETTLE_LOAD = settle_load(SETTLE);
  localparam logic [1:0]       IDX_LAST    = 2'(BYTES_PER_REG - 1);

  state_t      state_d, state_q;
  logic [4:0]  addr_d, addr_q;
  logic [31:0] cap_d, cap_q;
  logic [1:0]  idx_d, idx_q;
  logic        hs_s;
  logic        tmr_load_s, tmr_dec_s, tmr_expired_s;

  // tx_valid is a pure state decode, so the handshake has no output path.
  assign hs_s = tx_valid & tx_ready;

  sm_dbg_settle_timer #(
    .W (CNT_W)
  ) u_settle (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (tmr_load_s),
    .load_val (SETTLE_LOAD),
    .dec      (tmr_dec_s),
    .expired  (tmr_expired_s)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:    if (start) state_d = ST_HEADER; else state_d = ST_IDLE;
      ST_HEADER:  if (hs_s) state_d = ST_SETTLE; else state_d = ST_HEADER;
      ST_SETTLE:  if (tmr_expired_s) state_d = ST_CAPTURE; else state_d = ST_SETTLE;
      ST_CAPTURE: state_d = ST_SEND;
      ST_SEND: begin
        if (hs_s && (idx_q == IDX_LAST)) begin
          if (addr_q == REG_LAST) state_d = ST_DONE;
          else                    state_d = ST_SETTLE;
        end else begin
          state_d = ST_SEND;
        end
      end
      ST_DONE:    state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  // Datapath next values and settle timer control.
  always_comb begin
    addr_d     = addr_q;
    cap_d      = cap_q;
    idx_d      = idx_q;
    tmr_load_s = 1'b0;
    tmr_dec_s  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) addr_d = 5'd0; else addr_d = addr_q;
      end
      ST_HEADER: begin
        tmr_load_s = hs_s;
      end
      ST_SETTLE: begin
        tmr_dec_s = 1'b1;
      end
      ST_CAPTURE: begin
        cap_d = regData;
        idx_d = 2'd0;
      end
      ST_SEND: begin
        if (hs_s && (idx_q != IDX_LAST)) begin
          cap_d = {8'h00, cap_q[31:8]};
          idx_d = idx_q + 2'd1;
        end else if (hs_s && (addr_q != REG_LAST)) begin
          addr_d     = addr_q + 5'd1;
          tmr_load_s = 1'b1;
        end else begin
          cap_d = cap_q;
        end
      end
      ST_DONE: begin
        addr_d = 5'd0;
      end
      default: begin
        addr_d = 5'd0;
      end
    endcase
  end

  // Datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q <= 5'd0;
      cap_q  <= 32'd0;
      idx_q  <= 2'd0;
    end else begin
      addr_q <= addr_d;
      cap_q  <= cap_d;
      idx_q  <= idx_d;
    end
  end

  // Output decode from state and registers only.
  always_comb begin
    regAddr  = addr_q;
    tx_data  = 8'h00;
    tx_valid = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    case (state_q)
      ST_IDLE:    busy = 1'b0;
      ST_HEADER:  begin tx_data = HEADER;     tx_valid = 1'b1; busy = 1'b1; end
      ST_SETTLE:  busy = 1'b1;
      ST_CAPTURE: busy = 1'b1;
      ST_SEND:    begin tx_data = cap_q[7:0]; tx_valid = 1'b1; busy = 1'b1; end
      ST_DONE:    done = 1'b1;
      default:    busy = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_sm_reg_dumper.sv
// Self-checking bench for sm_reg_dumper: randomized backpressure against a
// frame model built directly from the dump format.
module tb_sm_reg_dumper;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic tx_ready = 1'b1;
  logic glitch = 1'b0;
  logic sel = 1'b0;

  always #5 clk = ~clk;

  logic [4:0]  addr0, addr1, a0_d1, a0_d2, a1_d1, a1_d2;
  logic [31:0] rd0, rd1;
  logic [7:0]  d0, d1;
  logic        v0, v1, b0, b1, dn0, dn1;

  // CPU side model: register value appears two cycles after the address.
  always @(posedge clk) begin
    a0_d1 <= addr0; a0_d2 <= a0_d1;
    a1_d1 <= addr1; a1_d2 <= a1_d1;
  end
  assign rd0 = glitch ? 32'h1234_5678 : (32'hDEAD_0000 | {27'd0, a0_d2});
  assign rd1 = glitch ? 32'h1234_5678 : (32'hDEAD_0000 | {27'd0, a1_d2});

  sm_reg_dumper #(.SETTLE(4), .HEADER(8'hA5)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .regAddr(addr0), .regData(rd0),
    .tx_data(d0), .tx_valid(v0), .tx_ready(tx_ready), .busy(b0), .done(dn0)
  );

  sm_reg_dumper #(.SETTLE(1), .HEADER(8'hA5)) dut_s1 (
    .clk(clk), .rst_n(rst_n), .start(start), .regAddr(addr1), .regData(rd1),
    .tx_data(d1), .tx_valid(v1), .tx_ready(tx_ready), .busy(b1), .done(dn1)
  );

  wire [7:0] o_data  = sel ? d1 : d0;
  wire       o_valid = sel ? v1 : v0;
  wire       o_busy  = sel ? b1 : b0;
  wire       o_done  = sel ? dn1 : dn0;
  wire [4:0] o_addr  = sel ? addr1 : addr0;

  int n_pass = 0;
  int n_chk  = 0;

  logic [7:0] rx[$];
  int done_cyc, done_cnt, busy_err, stab_err, addr_err;
  logic ab_hit, ab_valid, ab_busy, ab_done;
  logic [4:0] ab_addr;

  // Expected frame: A5, then x0..x31 = DEAD0000|r, little-endian.
  function automatic int frame_diff();
    int bad;
    logic [31:0] v;
    logic [7:0] e;
    bad = 0;
    if (rx.size() < 129) bad += 129 - rx.size();
    for (int i = 0; i < 129 && i < rx.size(); i++) begin
      if (i == 0) e = 8'hA5;
      else begin
        v = 32'hDEAD_0000 | 32'((i - 1) / 4);
        e = 8'(v >> (8 * ((i - 1) % 4)));
      end
      if (rx[i] !== e) bad++;
    end
    return bad;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; start = 1'b0; tx_ready = 1'b1; glitch = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  task automatic run_frame(input int hold, input int pulse_at, input bit bp,
                           input bit iso, input int abort_at, input int extra);
    logic [7:0] pd;
    logic pv, pr;
    logic [4:0] pa;
    int dcount;
    rx.delete();
    done_cyc = -1; done_cnt = 0; busy_err = 0; stab_err = 0; addr_err = 0;
    ab_hit = 1'b0; ab_valid = 1'b1; ab_busy = 1'b1; ab_done = 1'b1; ab_addr = 5'h1f;
    pv = 1'b0; pr = 1'b1; pd = 8'h00; pa = 5'd0; dcount = 0;
    @(negedge clk);
    start = 1'b1; tx_ready = 1'b1;
    for (int c = 1; c <= 3000; c++) begin
      @(negedge clk);
      start = (c < hold) || (c == pulse_at);
      if (pv && !pr && (o_valid !== 1'b1 || o_data !== pd)) stab_err++;
      if (o_addr !== pa &&
          (dcount == 0 || dcount % 4 != 0 || o_addr !== 5'((dcount / 4) % 32))) addr_err++;
      if (o_done === 1'b1) begin
        done_cnt++;
        if (done_cyc < 0) done_cyc = c;
      end
      if (o_busy !== (done_cyc < 0)) busy_err++;
      if (abort_at >= 0 && dcount == abort_at && o_valid === 1'b1) begin
        rst_n = 1'b0;
        #1;
        ab_hit = 1'b1; ab_valid = o_valid; ab_busy = o_busy;
        ab_done = o_done; ab_addr = o_addr;
        break;
      end
      tx_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      glitch = iso && (o_valid === 1'b1) && (o_addr == 5'd3);
      if (o_valid === 1'b1 && tx_ready) begin
        rx.push_back(o_data);
        if (rx.size() > 1) dcount++;
      end
      pv = o_valid; pr = tx_ready; pd = o_data; pa = o_addr;
      if (done_cyc >= 0 && c >= done_cyc + extra) break;
    end
    start = 1'b0; tx_ready = 1'b1; glitch = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_chk++;
    if ({v0, b0, dn0, addr0, d0} !== 16'd0)
      $display("FAIL reset_outputs: got valid=%b busy=%b done=%b addr=%0d data=%h, want all 0",
               v0, b0, dn0, addr0, d0);
    else n_pass++;
    do_reset();
    n_chk++;
    if ({v0, b0, dn0, addr0} !== 8'd0)
      $display("FAIL reset_idle: got valid=%b busy=%b done=%b addr=%0d, want all 0", v0, b0, dn0, addr0);
    else n_pass++;
  endtask

  task automatic test_basic();
    int bad;
    do_reset();
    run_frame(0, -1, 1'b0, 1'b0, -1, 2);
    bad = frame_diff();
    n_chk++; if (bad != 0) $display("FAIL basic_frame: got %0d bad bytes, want 0", bad); else n_pass++;
    n_chk++; if (rx.size() != 129) $display("FAIL basic_len: got %0d, want 129", rx.size()); else n_pass++;
    n_chk++; if (done_cyc != 290) $display("FAIL basic_done_cycle: got %0d, want 290", done_cyc); else n_pass++;
    n_chk++; if (busy_err != 0) $display("FAIL basic_busy: got %0d bad cycles, want 0", busy_err); else n_pass++;
    n_chk++; if (addr_err != 0) $display("FAIL basic_addr: got %0d bad changes, want 0", addr_err); else n_pass++;
    n_chk++; if (done_cnt != 1) $display("FAIL basic_done_count: got %0d, want 1", done_cnt); else n_pass++;
  endtask

  task automatic test_backpressure();
    int bad;
    do_reset();
    run_frame(0, -1, 1'b1, 1'b0, -1, 2);
    bad = frame_diff();
    n_chk++; if (bad != 0 || rx.size() != 129)
      $display("FAIL bp_frame: got %0d bad bytes len %0d, want 0 and 129", bad, rx.size()); else n_pass++;
    n_chk++; if (stab_err != 0) $display("FAIL bp_stable: got %0d violations, want 0", stab_err); else n_pass++;
    n_chk++; if (addr_err != 0) $display("FAIL bp_addr: got %0d bad changes, want 0", addr_err); else n_pass++;
    n_chk++; if (done_cnt != 1) $display("FAIL bp_done_count: got %0d, want 1", done_cnt); else n_pass++;
  endtask

  task automatic test_settle();
    int bad;
    do_reset();
    sel = 1'b1;
    run_frame(0, -1, 1'b0, 1'b0, -1, 2);
    sel = 1'b0;
    bad = frame_diff();
    n_chk++; if (bad == 0) $display("FAIL settle1_wrong_data: got %0d bad bytes, want nonzero", bad); else n_pass++;
    n_chk++; if (rx.size() != 129) $display("FAIL settle1_len: got %0d, want 129", rx.size()); else n_pass++;
    n_chk++; if (done_cyc != 194) $display("FAIL settle1_done_cycle: got %0d, want 194", done_cyc); else n_pass++;
  endtask

  task automatic test_start_hold();
    do_reset();
    run_frame(300, -1, 1'b0, 1'b0, -1, 2);
    n_chk++; if (done_cnt != 1) $display("FAIL hold_done_count: got %0d, want 1", done_cnt); else n_pass++;
    n_chk++; if (done_cyc != 290) $display("FAIL hold_done_cycle: got %0d, want 290", done_cyc); else n_pass++;
    n_chk++; if (rx.size() != 130 || rx[rx.size() - 1] !== 8'hA5)
      $display("FAIL hold_restart: got len %0d, want 130 ending in A5", rx.size()); else n_pass++;
  endtask

  task automatic test_start_pulse();
    do_reset();
    run_frame(0, 100, 1'b0, 1'b0, -1, 4);
    n_chk++; if (rx.size() != 129 || frame_diff() != 0)
      $display("FAIL pulse_frame: got len %0d, want 129 correct bytes", rx.size()); else n_pass++;
    n_chk++; if (done_cnt != 1 || done_cyc != 290)
      $display("FAIL pulse_done: got count %0d cycle %0d, want 1 at 290", done_cnt, done_cyc); else n_pass++;
  endtask

  task automatic test_reset_mid();
    int late_done;
    do_reset();
    run_frame(0, -1, 1'b1, 1'b0, 30, 2);
    n_chk++; if (ab_hit !== 1'b1) $display("FAIL abort_reached: got %b, want 1", ab_hit); else n_pass++;
    n_chk++; if ({ab_valid, ab_busy, ab_done, ab_addr} !== 8'd0)
      $display("FAIL abort_outputs: got valid=%b busy=%b done=%b addr=%0d, want all 0",
               ab_valid, ab_busy, ab_done, ab_addr); else n_pass++;
    late_done = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (dn0 === 1'b1) late_done++;
    end
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (dn0 === 1'b1) late_done++;
    end
    n_chk++; if (late_done != 0) $display("FAIL abort_no_done: got %0d pulses, want 0", late_done); else n_pass++;
    run_frame(0, -1, 1'b0, 1'b0, -1, 2);
    n_chk++; if (rx.size() != 129 || frame_diff() != 0 || done_cyc != 290)
      $display("FAIL abort_restart: got len %0d bad %0d done %0d, want 129 0 290",
               rx.size(), frame_diff(), done_cyc); else n_pass++;
  endtask

  task automatic test_isolation();
    do_reset();
    run_frame(0, -1, 1'b1, 1'b1, -1, 2);
    n_chk++; if (rx.size() != 129 || frame_diff() != 0)
      $display("FAIL isolation_frame: got len %0d bad %0d, want 129 0", rx.size(), frame_diff()); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_settle();
    test_start_hold();
    test_start_pulse();
    test_reset_mid();
    test_isolation();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
